// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants and state encoding for the CORDIC front-end
package cordic_pkg;

   localparam logic [3:0] FUNC_COSH = 4'd4;
   localparam logic [3:0] FUNC_SINH = 4'd5;
   localparam logic [3:0] FUNC_IDLE = 4'hF;

   localparam int CORDIC_LATENCY = 17;

   typedef logic [2:0] state_t;

   localparam state_t ST_FLUSH = 3'd0;
   localparam state_t ST_IDLE  = 3'd1;
   localparam state_t ST_START = 3'd2;
   localparam state_t ST_WAIT  = 3'd3;
   localparam state_t ST_RESP  = 3'd4;

endpackage

// File: rtl/cordic_lat_counter.sv
// rtl/cordic_lat_counter.sv - loadable down-counter with zero flag
// Saturates at zero so the owner can sit on the zero flag for a cycle.
module cordic_lat_counter import cordic_pkg::*; #(
   parameter int               WIDTH     = 5,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= RESET_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/cordic_op_sequencer.sv
// rtl/cordic_op_sequencer.sv - issues one CORDIC operation at a time and returns the sampled result
// FLUSH after reset lets a possibly still-iterating unit finish before it can be started again.
module cordic_op_sequencer import cordic_pkg::*; #(
   parameter int          LATENCY   = CORDIC_LATENCY,
   parameter logic [15:0] FUNC_MASK = 16'h0030,
   parameter logic [3:0]  IDLE_FUNC = FUNC_IDLE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_func,
   input  logic [15:0] req_arg,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [3:0]  rsp_func,
   output logic        rsp_err,
   output logic        unit_st,
   output logic [15:0] unit_z0,
   output logic [3:0]  unit_func,
   input  logic [31:0] unit_result
);

   localparam int            CW       = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] LAT_FULL = CW'(LATENCY);
   localparam logic [CW-1:0] LAT_LOAD = CW'(LATENCY - 1);

   generate
      if (LATENCY < 2) begin : g_bad_latency
         $error("cordic_op_sequencer: LATENCY must be at least 2");
      end
   endgenerate

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  func_q;
   logic [15:0] arg_q;
   logic [31:0] data_q;
   logic        err_q;
   logic        cnt_zero;
   logic        supported;

   assign supported = FUNC_MASK[req_func];

   always_comb begin
      state_nxt = state;
      case (state)
         ST_FLUSH: if (cnt_zero) state_nxt = ST_IDLE;
         ST_IDLE:  if (req_valid) state_nxt = supported ? ST_START : ST_RESP;
         ST_START: state_nxt = ST_WAIT;
         ST_WAIT:  if (cnt_zero) state_nxt = ST_RESP;
         ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_FLUSH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_FLUSH;
      end else begin
         state <= state_nxt;
      end
   end

   // Unsupported codes skip the unit entirely and answer with an error at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         func_q <= 4'd0;
         arg_q  <= 16'd0;
         data_q <= 32'd0;
         err_q  <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && req_valid) begin
            func_q <= req_func;
            if (supported) begin
               arg_q <= req_arg;
            end else begin
               data_q <= 32'd0;
               err_q  <= 1'b1;
            end
         end
         if ((state == ST_WAIT) && cnt_zero) begin
            data_q <= unit_result;
            err_q  <= 1'b0;
         end
      end
   end

   cordic_lat_counter #(
      .WIDTH     (CW),
      .RESET_VAL (LAT_FULL)
   ) u_lat_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == ST_START),
      .load_val (LAT_LOAD),
      .dec      ((state == ST_FLUSH) || (state == ST_WAIT)),
      .zero     (cnt_zero)
   );

   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign rsp_data  = data_q;
   assign rsp_func  = func_q;
   assign rsp_err   = err_q;
   assign unit_st   = (state == ST_START);
   assign unit_z0   = arg_q;
   assign unit_func = ((state == ST_FLUSH) || (state == ST_IDLE)) ? IDLE_FUNC : func_q;

endmodule

// File: tb/tb_cordic_op_sequencer.sv
// tb/tb_cordic_op_sequencer.sv - scoreboard bench for cordic_op_sequencer with a CORDIC unit stub
module tb_cordic_op_sequencer;
   import cordic_pkg::*;

   localparam int LAT = CORDIC_LATENCY;

   typedef struct packed {
      logic [3:0]  func;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_func = 4'd0;
   logic [15:0] req_arg = 16'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_func;
   logic        rsp_err;
   logic        unit_st;
   logic [15:0] unit_z0;
   logic [3:0]  unit_func;
   logic [31:0] unit_result;

   rsp_t        exp_q[$];
   rsp_t        obs_q[$];
   int          exp_idx = 0;
   int          obs_idx = 0;
   int          st_count = 0;
   int          st_double = 0;
   int          st_bad = 0;
   logic [15:0] last_z0 = 16'd0;
   logic        prev_st = 1'b0;
   logic [3:0]  func_trace[$];
   logic [3:0]  last_func = 4'hF;
   int          st_age = 0;
   int          n_pass = 0;
   int          n_total = 0;

   cordic_op_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_func    (req_func),
      .req_arg     (req_arg),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_func    (rsp_func),
      .rsp_err     (rsp_err),
      .unit_st     (unit_st),
      .unit_z0     (unit_z0),
      .unit_func   (unit_func),
      .unit_result (unit_result)
   );

   always #5 clk = ~clk;

   // Unit stub: the bus carries a valid result only LAT cycles after the start cycle.
   always @(posedge clk) begin
      if (unit_st) st_age <= 1;
      else if (st_age != 0 && st_age < 1000) st_age <= st_age + 1;
   end

   assign unit_result = (st_age == LAT && unit_func == FUNC_COSH) ? 32'h0000_1234 :
                        (st_age == LAT && unit_func == FUNC_SINH) ? 32'h0000_5678 : 32'hDEAD_BEEF;

   always @(negedge clk) begin
      if (rsp_valid && rsp_ready) obs_q.push_back({rsp_func, rsp_data, rsp_err});
      if (unit_st) begin
         st_count++;
         last_z0 = unit_z0;
         if (prev_st) st_double++;
         if (unit_func == 4'hF) st_bad++;
      end
      prev_st = unit_st;
      if (unit_func !== last_func) begin
         func_trace.push_back(unit_func);
         last_func = unit_func;
      end
   end

   function automatic rsp_t model(input logic [3:0] f);
      if (f == FUNC_COSH) return {f, 32'h0000_1234, 1'b0};
      if (f == FUNC_SINH) return {f, 32'h0000_5678, 1'b0};
      return {f, 32'h0000_0000, 1'b1};
   endfunction

   task automatic send_req(input logic [3:0] f, input logic [15:0] a, output int lat);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      req_func = f; req_arg = a; req_valid = 1'b1;
      exp_q.push_back(model(f));
      @(posedge clk); #1 req_valid = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
   endtask

   task automatic get_rsp(output rsp_t o, output rsp_t e, output bit ok);
      int n = 0;
      while (obs_idx >= obs_q.size() && n < 200) begin @(negedge clk); n++; end
      ok = (obs_idx < obs_q.size());
      o = ok ? obs_q[obs_idx] : '0;
      if (ok) obs_idx++;
      e = (exp_idx < exp_q.size()) ? exp_q[exp_idx] : '0;
      exp_idx++;
   endtask

   task automatic measure_flush(output int n, output int bad);
      n = 0; bad = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         if (unit_st !== 1'b0 || unit_func !== 4'hF) bad++;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      int n, bad;
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_total++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", req_ready); else n_pass++;
      n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
      n_total++; if (rsp_data !== 32'd0) $display("FAIL rst_rsp_data: got %h want 0", rsp_data); else n_pass++;
      n_total++; if (rsp_func !== 4'd0) $display("FAIL rst_rsp_func: got %h want 0", rsp_func); else n_pass++;
      n_total++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err: got %b want 0", rsp_err); else n_pass++;
      n_total++; if (unit_st !== 1'b0) $display("FAIL rst_unit_st: got %b want 0", unit_st); else n_pass++;
      n_total++; if (unit_z0 !== 16'd0) $display("FAIL rst_unit_z0: got %h want 0", unit_z0); else n_pass++;
      n_total++; if (unit_func !== 4'hF) $display("FAIL rst_unit_func: got %h want f", unit_func); else n_pass++;
      @(posedge clk); #1 rst_n = 1'b1;
      measure_flush(n, bad);
      n_total++; if (n != LAT + 1) $display("FAIL flush_len: got %0d want %0d", n, LAT + 1); else n_pass++;
      n_total++; if (bad != 0) $display("FAIL flush_unit_idle: got %0d bad cycles want 0", bad); else n_pass++;
   endtask

   task automatic test_supported;
      int lat, s0;
      rsp_t o, e;
      bit ok;
      rsp_ready = 1'b1;
      s0 = st_count;
      send_req(FUNC_COSH, 16'h2000, lat);
      n_total++; if (lat != LAT + 1) $display("FAIL sup_latency: got %0d want %0d", lat, LAT + 1); else n_pass++;
      get_rsp(o, e, ok);
      n_total++; if (!ok) $display("FAIL sup_present: got none want 1 response"); else n_pass++;
      n_total++; if (st_count - s0 != 1) $display("FAIL sup_st_pulses: got %0d want 1", st_count - s0); else n_pass++;
      n_total++; if (last_z0 !== 16'h2000) $display("FAIL sup_z0: got %h want 2000", last_z0); else n_pass++;
      n_total++; if (st_double != 0 || st_bad != 0) $display("FAIL sup_st_shape: got %0d/%0d want 0/0", st_double, st_bad); else n_pass++;
      n_total++; if (o.data !== e.data) $display("FAIL sup_data: got %h want %h", o.data, e.data); else n_pass++;
      n_total++; if (o.func !== e.func) $display("FAIL sup_func: got %h want %h", o.func, e.func); else n_pass++;
      n_total++; if (o.err !== e.err) $display("FAIL sup_err: got %b want %b", o.err, e.err); else n_pass++;
   endtask

   task automatic test_unsupported;
      int lat, s0;
      rsp_t o, e;
      bit ok;
      rsp_ready = 1'b1;
      s0 = st_count;
      send_req(4'd7, 16'h1111, lat);
      n_total++; if (lat != 0) $display("FAIL unsup_latency: got %0d want 0", lat); else n_pass++;
      get_rsp(o, e, ok);
      n_total++; if (st_count - s0 != 0) $display("FAIL unsup_st_pulses: got %0d want 0", st_count - s0); else n_pass++;
      n_total++; if (o.data !== e.data) $display("FAIL unsup_data: got %h want %h", o.data, e.data); else n_pass++;
      n_total++; if (o.func !== e.func) $display("FAIL unsup_func: got %h want %h", o.func, e.func); else n_pass++;
      n_total++; if (o.err !== e.err) $display("FAIL unsup_err: got %b want %b", o.err, e.err); else n_pass++;
   endtask

   task automatic test_backpressure;
      int lat, bad, n0;
      rsp_t o, e;
      bit ok;
      rsp_ready = 1'b0;
      send_req(FUNC_COSH, 16'h0AAA, lat);
      req_func = FUNC_SINH; req_arg = 16'h3000; req_valid = 1'b1;
      exp_q.push_back(model(FUNC_SINH));
      n0 = obs_q.size();
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_1234 || rsp_func !== FUNC_COSH
             || req_ready !== 1'b0 || unit_st !== 1'b0) bad++;
      end
      n_total++; if (bad != 0 || obs_q.size() != n0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); else n_pass++;
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      @(negedge clk);
      n_total++; if (req_ready !== 1'b1) $display("FAIL bp_idle_next: got %b want 1", req_ready); else n_pass++;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      n_total++; if (unit_st !== 1'b1 || unit_z0 !== 16'h3000) $display("FAIL bp_queued_start: got st=%b z0=%h want st=1 z0=3000", unit_st, unit_z0); else n_pass++;
      rsp_ready = 1'b1;
      repeat (2) begin
         get_rsp(o, e, ok);
         n_total++; if (!ok || o !== e) $display("FAIL bp_rsp: got %h want %h", o, e); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_wait;
      int n, bad, n0, s0, w;
      rsp_ready = 1'b1;
      n0 = obs_q.size();
      s0 = st_count;
      w = 0;
      @(negedge clk);
      while (!req_ready && w < 200) begin @(negedge clk); w++; end
      req_func = FUNC_COSH; req_arg = 16'h4444; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_total++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || unit_st !== 1'b0)
         $display("FAIL midrst_handshake: got rdy=%b vld=%b st=%b want 0/0/0", req_ready, rsp_valid, unit_st); else n_pass++;
      n_total++; if (unit_func !== 4'hF || unit_z0 !== 16'd0)
         $display("FAIL midrst_unit: got func=%h z0=%h want f/0000", unit_func, unit_z0); else n_pass++;
      n_total++; if (rsp_data !== 32'd0 || rsp_func !== 4'd0 || rsp_err !== 1'b0)
         $display("FAIL midrst_rsp: got %h/%h/%b want 0/0/0", rsp_data, rsp_func, rsp_err); else n_pass++;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      measure_flush(n, bad);
      n_total++; if (n != LAT + 1) $display("FAIL midrst_flush_len: got %0d want %0d", n, LAT + 1); else n_pass++;
      n_total++; if (obs_q.size() != n0) $display("FAIL midrst_no_rsp: got %0d responses want %0d", obs_q.size(), n0); else n_pass++;
      n_total++; if (st_count - s0 != 1 || bad != 0) $display("FAIL midrst_st: got %0d pulses %0d bad want 1/0", st_count - s0, bad); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int lat, t0, s0;
      rsp_t o, e;
      bit ok;
      logic [3:0] tr0, tr1, tr2;
      rsp_ready = 1'b1;
      t0 = func_trace.size();
      s0 = st_count;
      send_req(FUNC_COSH, 16'h0100, lat);
      send_req(FUNC_SINH, 16'h0200, lat);
      repeat (2) begin
         get_rsp(o, e, ok);
         n_total++; if (!ok || o !== e) $display("FAIL b2b_rsp: got %h want %h", o, e); else n_pass++;
      end
      repeat (3) @(negedge clk);
      tr0 = (func_trace.size() > t0)     ? func_trace[t0]     : 4'h0;
      tr1 = (func_trace.size() > t0 + 1) ? func_trace[t0 + 1] : 4'h0;
      tr2 = (func_trace.size() > t0 + 2) ? func_trace[t0 + 2] : 4'h0;
      n_total++; if (tr0 !== 4'h4 || tr1 !== 4'hF || tr2 !== 4'h5)
         $display("FAIL b2b_func_seq: got %h,%h,%h want 4,f,5", tr0, tr1, tr2); else n_pass++;
      n_total++; if (st_count - s0 != 2 || st_double != 0 || st_bad != 0)
         $display("FAIL b2b_st: got %0d pulses dbl=%0d bad=%0d want 2/0/0", st_count - s0, st_double, st_bad); else n_pass++;
      n_total++; if (last_z0 !== 16'h0200) $display("FAIL b2b_z0: got %h want 0200", last_z0); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_supported();
      test_unsupported();
      test_backpressure();
      test_reset_mid_wait();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cordic_op_sequencer.md
Name: cordic_op_sequencer

Overview:
- Front-end controller for the shared CORDIC hyperbolic unit.
- Accepts one operation request at a time (function code plus 16-bit angle) and issues a single-cycle start pulse with the angle to the unit.
- Holds the function select steady, counts the unit's fixed iteration latency, and samples the shared 32-bit result bus.
- Returns the sample through a valid/ready response handshake, with an error flag for function codes the unit does not implement.

Parameters:
- LATENCY, 17, cycles from the start-pulse cycle to the cycle in which the result bus is valid (1 load + 15 iterations + 1 finish).
- FUNC_MASK, 16'h0030, bit f set means func code f is served by the unit (default: 4 = cosh, 5 = sinh).
- IDLE_FUNC, 4'hF, func code driven while no operation is active, so no unit drives the result bus.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_func  in  4  requested function code
- req_arg  in  16  angle operand (unit z_0 format)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  32  sampled result
- rsp_func  out  4  func code of this response
- rsp_err  out  1  unsupported func code
- unit_st  out  1  start pulse to the CORDIC unit
- unit_z0  out  16  angle to the CORDIC unit
- unit_func  out  4  function select to the unit and the result-bus owners
- unit_result  in  32  shared result bus

Behaviour:
- Reset (async, rst_n=0):
  - state=FLUSH, counter=LATENCY.
  - req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, rsp_func=0.
  - unit_st=0, unit_z0=0, unit_func=IDLE_FUNC.
- Reset mid-operation: everything aborts, no response is produced, and FLUSH is re-entered. The unit has no reset and may still be iterating; a start pulse during its iteration state is ignored, so FLUSH is mandatory.
- States and transitions:
  - FLUSH: counter decrements each cycle; at 0, go to IDLE. req_ready=0.
  - IDLE: req_ready=1.
    - On req_valid with FUNC_MASK[req_func]=1: latch func and arg, go to START.
    - On req_valid with FUNC_MASK[req_func]=0: latch func, load rsp_data=0 and rsp_err=1, go to RESP (the unit is never started).
  - START (exactly 1 cycle): unit_st=1, unit_z0=latched arg, unit_func=latched func. counter loads LATENCY-1. Go to WAIT.
  - WAIT: unit_st=0. counter decrements; while counter=0, register rsp_data<=unit_result, rsp_err<=0, then go to RESP.
  - RESP: rsp_valid=1, and rsp_data/rsp_func/rsp_err are held stable. On rsp_ready, go to IDLE the next cycle.
- unit_func = latched func in START, WAIT and RESP; IDLE_FUNC in FLUSH and IDLE.
- unit_z0 holds its last value outside START. unit_st is never high for 2 consecutive cycles, and is never high outside START.
- Latency (supported op): request accept edge, then the sample edge LATENCY+1 edges later; rsp_valid is high the following cycle. With default parameters, rsp_valid rises 18 edges after the accept edge.
- req_ready is low in all states except IDLE. There is no queuing: the response must be consumed before the next request is accepted.
- rsp_ready high outside RESP is ignored. rsp_valid is held indefinitely under backpressure.
- req_valid high during START/WAIT/RESP is not accepted; the request is held by the requester.
- Counter width: $clog2(LATENCY+1). LATENCY must be at least 2; a smaller value is a parameter error, enforced by an elaboration-time check.

Decomposition:
- Shared package cordic_pkg holds:
  - FUNC_COSH=4'd4, FUNC_SINH=4'd5, FUNC_IDLE=4'hF.
  - CORDIC_LATENCY=17.
  - The state enum (FLUSH, IDLE, START, WAIT, RESP).
- One sub-module is natural: cordic_lat_counter (loadable down-counter with zero flag), used by both FLUSH and WAIT.

Test Plan:
- Reset release: req_ready stays 0 for LATENCY+1 cycles, then goes 1. unit_st=0 and unit_func=4'hF throughout.
- Supported op: the bench stub drives unit_result=32'h0000_1234 when unit_func=4 and LATENCY cycles after unit_st. Request func=4, arg=16'h2000.
  - Required: exactly one unit_st pulse with unit_z0=16'h2000.
  - Required: rsp_valid 18 edges after accept, with rsp_data=32'h0000_1234, rsp_func=4, rsp_err=0.
- Unsupported op: func=4'd7 -> no unit_st pulse; rsp_valid 1 cycle after accept, with rsp_err=1 and rsp_data=0.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stay stable, req_ready=0. Then rsp_ready=1 for 1 cycle -> IDLE on the next cycle, and a queued func=5 request is accepted.
- Reset mid-WAIT: rst_n=0 at 5 cycles after unit_st -> all outputs return to reset values immediately and no response appears. After release, FLUSH lasts LATENCY+1 cycles before req_ready.
- Back-to-back: func=4 then func=5 with rsp_ready tied high -> two responses in order, unit_func switching 4 -> 4'hF -> 5, each with exactly one unit_st pulse.
